// File: rtl/calc_write_addr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : calc_write_addr                                              |
// | Description : Write-address calculator for an 8-bank extrinsic memory.     |
// |               Captures the read row address and bank map while a           |
// |               half-iteration runs, queues them in a small FIFO, and pairs  |
// |               each queued entry with an arriving extrinsic word. Lane data |
// |               is routed back to the banks it was read from.                |
// |               Optional duplicate-bank check on popped maps is enabled by   |
// |               defining CALC_WRITE_ADDR_PERM_CHECK_EN.                      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module calc_write_addr #(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                decMode,
  input  logic [ADDR_W-1:0]   blockSize,
  input  logic [ADDR_W-1:0]   rd_addr,
  input  logic [23:0]         rd_resort,
  input  logic                ext_valid,
  input  logic [8*DATA_W-1:0] ext_data,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [8*DATA_W-1:0] wr_data,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int c_ptr_w = $clog2(FIFO_DEPTH);
  localparam int c_map_w = 24;
  localparam int c_ent_w = ADDR_W + c_map_w;
  localparam logic [c_ptr_w:0] c_full_cnt = (c_ptr_w + 1)'(FIFO_DEPTH);
  // Lane i -> bank i, i.e. {7,6,5,4,3,2,1,0} packed 3 bits per lane.
  localparam logic [c_map_w-1:0] c_ident_map = 24'hFAC688;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                mode_q, mode_d;
  logic [ADDR_W-1:0]   push_cnt_q, push_cnt_d;
  logic [ADDR_W-1:0]   wr_cnt_q, wr_cnt_d;
  logic [c_ptr_w-1:0]  wr_ptr_q, wr_ptr_d;
  logic [c_ptr_w-1:0]  rd_ptr_q, rd_ptr_d;
  logic [c_ptr_w:0]    occ_q, occ_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [8*DATA_W-1:0] wr_data_q, wr_data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic [c_ent_w-1:0]  fifo_mem_q [FIFO_DEPTH];

  logic                start_acc;
  logic                active;
  logic                fifo_full;
  logic                fifo_empty;
  logic                pop;
  logic                push_try;
  logic                push;
  logic [c_ent_w-1:0]  push_entry;
  logic [c_ent_w-1:0]  head;
  logic [ADDR_W-1:0]   head_addr;
  logic [c_map_w-1:0]  head_map;
  logic [8*DATA_W-1:0] routed;
  logic                perm_err;

  assign start_acc  = start && (state_q == ST_IDLE);
  assign active     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign fifo_full  = (occ_q == c_full_cnt);
  assign fifo_empty = (occ_q == '0);
  assign pop        = ext_valid && active && !fifo_empty;
  assign push_try   = (state_q == ST_RUN);
  // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
  assign push       = push_try && (!fifo_full || pop);
  assign push_entry = {rd_addr, (mode_q ? rd_resort : c_ident_map)};
  assign head       = fifo_mem_q[rd_ptr_q];
  assign head_addr  = head[c_ent_w-1 -: ADDR_W];
  assign head_map   = head[c_map_w-1:0];

  // Inverse permutation: lane i lands in bank head_map[i]; untargeted banks get 0.
  always_comb begin
    routed = '0;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 8; i++) begin
        if (head_map[3*i +: 3] == 3'(k)) begin
          routed[DATA_W*k +: DATA_W] = ext_data[DATA_W*i +: DATA_W];
        end
      end
    end
  end

`ifdef CALC_WRITE_ADDR_PERM_CHECK_EN
  logic map_dup;

  // Flag any bank index that appears in more than one lane of the popped map.
  always_comb begin
    map_dup = 1'b0;
    for (int i = 0; i < 8; i++) begin
      for (int j = i + 1; j < 8; j++) begin
        if (head_map[3*i +: 3] == head_map[3*j +: 3]) begin
          map_dup = 1'b1;
        end
      end
    end
  end

  assign perm_err = pop && mode_q && map_dup;
`else
  assign perm_err = 1'b0;
`endif

  // Next-state logic for the FSM, counters, FIFO pointers and registered outputs.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    push_cnt_d = push_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    wr_en_d    = pop;
    wr_addr_d  = pop ? head_addr : wr_addr_q;
    wr_data_d  = pop ? routed : wr_data_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_RUN;
          mode_d     = decMode;
          push_cnt_d = '0;
          wr_cnt_d   = '0;
        end
      end
      ST_RUN: begin
        push_cnt_d = push_cnt_q + 1'b1;
        if (push_cnt_d == blockSize) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (wr_cnt_q == blockSize) begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (pop) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      occ_d = occ_q + 1'b1;
    end else if (pop && !push) begin
      occ_d = occ_q - 1'b1;
    end

    // A new half-iteration always starts from an empty queue.
    if (start_acc) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end

    busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    done_d = (state_d == ST_DONE);
    err_d  = (start_acc ? 1'b0 : err_q)
           | (ext_valid && !pop)
           | (push_try && fifo_full && !pop)
           | perm_err;
  end

  // Control and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      mode_q     <= 1'b0;
      push_cnt_q <= '0;
      wr_cnt_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      push_cnt_q <= push_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Queue storage; contents are meaningless once the pointers are cleared.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= push_entry;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_calc_write_addr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_calc_write_addr                                           |
// | Description : Directed self-checking bench for calc_write_addr.            |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_calc_write_addr;

  logic        clk;
  logic        reset;
  logic        start;
  logic        dec_mode;
  logic [12:0] block_size;
  logic [12:0] rd_addr;
  logic [23:0] rd_resort;
  logic        ext_valid;
  logic [63:0] ext_data;
  logic        wr_en;
  logic [12:0] wr_addr;
  logic [63:0] wr_data;
  logic        busy;
  logic        done;
  logic        err;

  int n_checks;
  int n_fail;

  calc_write_addr #(
    .ADDR_W    (13),
    .DATA_W    (8),
    .FIFO_DEPTH(16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .decMode  (dec_mode),
    .blockSize(block_size),
    .rd_addr  (rd_addr),
    .rd_resort(rd_resort),
    .ext_valid(ext_valid),
    .ext_data (ext_data),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Lane i of the word = {s[3:0], i[3:0]}.
  function automatic logic [63:0] mk_ext(input int s);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = 8'((s << 4) | i);
    return r;
  endfunction

  // Map with lane i -> bank (i + rot) mod 8.
  function automatic logic [23:0] rot_map(input int rot);
    logic [23:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) m[3*i +: 3] = 3'((i + rot) % 8);
    return m;
  endfunction

  // Natural-order run: push rd_addr=base.. in cycles 1..bs, ext_valid lag cycles
  // after each push. Stops right after write number stop_after when nonzero.
  task automatic run_nat(input int bs, input int lag, input int base, input int stop_after);
    int  nwr;
    logic exp_we;
    nwr        = 0;
    block_size = 13'(bs);
    dec_mode   = 1'b0;
    rd_resort  = 24'h5A5A5A;
    start      = 1'b1;
    tick();
    start = 1'b0;
    check_val("nat_start_busy", busy, 1);
    check_val("nat_start_err", err, 0);
    for (int k = 1; k <= bs + lag + 1; k++) begin
      rd_addr   = 13'(base + k - 1);
      ext_valid = (k >= 1 + lag) && (k <= bs + lag);
      ext_data  = mk_ext(k);
      tick();
      exp_we = (k + 1 >= 2 + lag) && (k + 1 <= bs + lag + 1);
      check_val("nat_wr_en", wr_en, exp_we);
      if (exp_we) begin
        check_val("nat_wr_addr", wr_addr, 64'(base + k - 1 - lag));
        check_val("nat_wr_data", wr_data, mk_ext(k));
        nwr++;
        if (nwr == stop_after) begin
          ext_valid = 1'b0;
          return;
        end
      end
      check_val("nat_done", done, (k + 1) == (bs + lag + 2));
      check_val("nat_busy", busy, (k + 1) <= (bs + lag + 1));
    end
    ext_valid = 1'b0;
    check_val("nat_wr_addr_hold", wr_addr, 64'(base + bs - 1));
    check_val("nat_err", err, 0);
    tick();
    check_val("nat_idle_done", done, 0);
    check_val("nat_idle_busy", busy, 0);
  endtask

  // Two-row interleaved run; returns the two written words.
  task automatic run_pair(input logic [23:0] m0, input logic [23:0] m1,
                          input logic [63:0] d0, input logic [63:0] d1,
                          output logic [63:0] w0, output logic [63:0] w1);
    block_size = 13'd2;
    dec_mode   = 1'b1;
    start      = 1'b1;
    tick();
    start     = 1'b0;
    rd_addr   = 13'd10;
    rd_resort = m0;
    tick();
    rd_addr   = 13'd11;
    rd_resort = m1;
    ext_valid = 1'b1;
    ext_data  = d0;
    tick();
    check_val("pair_we0", wr_en, 1);
    check_val("pair_addr0", wr_addr, 10);
    w0        = wr_data;
    ext_data  = d1;
    rd_resort = 24'hFFFFFF;
    tick();
    ext_valid = 1'b0;
    check_val("pair_we1", wr_en, 1);
    check_val("pair_addr1", wr_addr, 11);
    w1 = wr_data;
    tick();
    check_val("pair_done", done, 1);
    check_val("pair_we_off", wr_en, 0);
    tick();
    check_val("pair_busy_off", busy, 0);
  endtask

  initial begin
    logic [63:0] w0;
    logic [63:0] w1;
    logic [23:0] dup_map;
    int          nwr;

    n_checks   = 0;
    n_fail     = 0;
    reset      = 1'b0;
    start      = 1'b0;
    dec_mode   = 1'b0;
    block_size = '0;
    rd_addr    = '0;
    rd_resort  = '0;
    ext_valid  = 1'b0;
    ext_data   = '0;
    repeat (3) tick();
    check_val("rst_wr_en", wr_en, 0);
    check_val("rst_wr_addr", wr_addr, 0);
    check_val("rst_wr_data", wr_data, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_err", err, 0);
    reset = 1'b1;
    tick();

    // Natural order, ext_valid three cycles after each push.
    run_nat(4, 3, 0, 0);

    // Interleaved: lane0->bank1 then lane0->bank2.
    run_pair(rot_map(1), rot_map(2), 64'h8877665544332211, 64'h8877665544332211, w0, w1);
    check_val("il_word0", w0, 64'h7766554433221188);
    check_val("il_bank1", 64'(w0[15:8]), 64'h11);
    check_val("il_bank0", 64'(w0[7:0]), 64'h88);
    check_val("il_word1", w1, 64'h6655443322118877);
    check_val("il_err", err, 0);

    // Bank 3 targeted by lanes 0 and 3; bank 0 targeted by nobody.
    dup_map      = rot_map(0);
    dup_map[2:0] = 3'd3;
    run_pair(dup_map, rot_map(0), 64'h8877665544332211, 64'h8877665544332211, w0, w1);
    check_val("dup_bank0_zero", 64'(w0[7:0]), 64'h00);
    check_val("dup_bank1", 64'(w0[15:8]), 64'h22);
    check_val("dup_word1", w1, 64'h8877665544332211);
`ifdef CALC_WRITE_ADDR_PERM_CHECK_EN
    check_val("dup_err", err, 1);
`else
    check_val("dup_err", err, 0);
`endif

    // Underflow in IDLE, then a run cut short by reset after two writes.
    ext_valid = 1'b1;
    ext_data  = 64'hDEAD_BEEF_0000_1111;
    tick();
    ext_valid = 1'b0;
    check_val("unf_wr_en", wr_en, 0);
    check_val("unf_err", err, 1);
    run_nat(8, 1, 200, 2);
    reset = 1'b0;
    #1;
    check_val("mrst_wr_en", wr_en, 0);
    check_val("mrst_wr_addr", wr_addr, 0);
    check_val("mrst_wr_data", wr_data, 0);
    check_val("mrst_busy", busy, 0);
    check_val("mrst_done", done, 0);
    check_val("mrst_err", err, 0);
    tick();
    tick();
    reset     = 1'b1;
    ext_valid = 1'b1;
    tick();
    ext_valid = 1'b0;
    check_val("mrst_first_we", wr_en, 0);
    check_val("mrst_first_busy", busy, 0);
    check_val("mrst_first_err", err, 1);
    run_nat(8, 1, 300, 0);

    // Overflow: 20 pushes into a 16-deep queue with nothing consumed.
    block_size = 13'd20;
    dec_mode   = 1'b0;
    start      = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      rd_addr = 13'(100 + k - 1);
      tick();
      check_val("ovf_wr_en", wr_en, 0);
      check_val("ovf_err", err, (k + 1) >= 18);
    end
    check_val("ovf_busy", busy, 1);
    nwr = 0;
    for (int j = 0; j < 19; j++) begin
      ext_valid = (j < 17);
      ext_data  = mk_ext(j);
      tick();
      if (wr_en) begin
        check_val("ovf_addr", wr_addr, 64'(100 + nwr));
        nwr++;
      end
    end
    check_val("ovf_writes", nwr, 16);
    check_val("ovf_stuck_busy", busy, 1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check_val("ovf_rst_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/calc_write_addr.md
CALC_WRITE_ADDR -- requirements
Module: calc_write_addr

Interface
REQ-001 SHALL have parameter ADDR_W, default 13, row-address width per bank.
REQ-002 SHALL have parameter DATA_W, default 8, extrinsic LLR width per lane.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16 (power of 2), address-FIFO depth.
REQ-004 SHALL have port clk  in  1  clock, rising edge.
REQ-005 SHALL have port reset  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  in  1  one-cycle pulse that begins a half-iteration.
REQ-007 SHALL have port decMode  in  1  0 = natural order, 1 = interleaved order.
REQ-008 SHALL have port blockSize  in  ADDR_W  rows per half-iteration, legal range 2 to 2^ADDR_W-1.
REQ-009 SHALL have port rd_addr  in  ADDR_W  row address issued by the read-address calculator this cycle.
REQ-010 SHALL have port rd_resort  in  24  read bank map, 3 bits per lane; lane i occupies [3i+2:3i].
REQ-011 SHALL have port ext_valid  in  1  8-lane extrinsic word valid.
REQ-012 SHALL have port ext_data  in  8*DATA_W  lane i occupies [DATA_W*(i+1)-1:DATA_W*i].
REQ-013 SHALL have port wr_en  out  1  bank write strobe, common to all 8 banks.
REQ-014 SHALL have port wr_addr  out  ADDR_W  row written in all banks.
REQ-015 SHALL have port wr_data  out  8*DATA_W  bank k occupies slice k.
REQ-016 SHALL have port busy  out  1  high in RUN and DRAIN.
REQ-017 SHALL have port done  out  1  one-cycle pulse at half-iteration end.
REQ-018 SHALL have port err  out  1  sticky error flag, cleared by start.

Function
REQ-019 SHALL implement FSM IDLE->RUN on start; RUN->DRAIN when push count reaches blockSize; DRAIN->DONE when write count reaches blockSize; DONE->IDLE unconditionally after 1 cycle.
REQ-020 SHALL ignore start outside IDLE.
REQ-021 SHALL, in RUN, push {rd_addr, rd_resort} into the FIFO every cycle, beginning the cycle after start, for exactly blockSize pushes.
REQ-022 SHALL, in decMode 0, store identity map {7,6,5,4,3,2,1,0} instead of rd_resort; decMode SHALL be sampled at start.
REQ-023 SHALL, on ext_valid in RUN or DRAIN with the FIFO non-empty, pop one entry and register a write: wr_en=1 at the next cycle (1-cycle latency), wr_addr=popped row.
REQ-024 SHALL route lane i data to bank slice resort_i (inverse of the read permutation); a bank targeted by no lane SHALL be written 0.
REQ-025 SHALL allow push and pop in the same cycle; occupancy then stays unchanged.
REQ-026 SHALL, when ext_valid is asserted with the FIFO empty or in IDLE, issue no write and set err.
REQ-027 SHALL, when a push is attempted with the FIFO full and no simultaneous pop, drop the push and set err.
REQ-028 SHALL use wrap-around FIFO pointers of log2(FIFO_DEPTH) bits plus a separate occupancy count of log2(FIFO_DEPTH)+1 bits.
REQ-029 SHALL count writes in an ADDR_W-bit counter; done SHALL assert in the DONE-state cycle, one cycle after the final wr_en.
REQ-030 SHALL hold wr_en=0 whenever no write occurs; wr_addr and wr_data then hold their last values.

Reset
REQ-031 SHALL, while reset=0, force state IDLE; wr_en, busy, done, err = 0; wr_addr, wr_data = 0; FIFO empty; both counters 0.
REQ-032 SHALL, on reset mid-operation, discard all FIFO contents, and the first cycle after release SHALL produce no write.

Configuration
REQ-033 SHALL, with macro CALC_WRITE_ADDR_PERM_CHECK_EN defined, check each popped interleaved map for duplicate bank indices; a duplicate sets err and the write still proceeds per REQ-024.
REQ-034 SHALL, without CALC_WRITE_ADDR_PERM_CHECK_EN, contain no check logic; err then depends only on REQ-026 and REQ-027.

Verification
REQ-035 SHALL verify natural mode: blockSize=4, decMode=0, rd_addr 0..3, ext_valid 3 cycles after each push -> wr_addr 0,1,2,3, wr_data==ext_data, done 1 cycle after the 4th wr_en.
REQ-036 SHALL verify interleaved mode: rd_resort={0,7,6,5,4,3,2,1} (lane0->bank1), ext lane0=0x11 -> wr_data bank1=0x11, bank0=lane7 value.
REQ-037 SHALL verify overflow: FIFO_DEPTH=16, blockSize=20, no ext_valid -> err=1 after the 17th push, and only 16 writes drain.
REQ-038 SHALL verify underflow: ext_valid in IDLE -> wr_en stays 0 and err=1; the next start clears err.
REQ-039 SHALL verify mid-run reset: assert reset after 2 of 8 writes -> all outputs 0 and state IDLE; a new start runs a clean 8-write sequence.
REQ-040 SHALL verify, with CALC_WRITE_ADDR_PERM_CHECK_EN defined, rd_resort containing bank 3 twice -> err=1; with the macro undefined, err=0.
